encoder_1553_queued: RTL and testbench

- Parametrised successor to the single-word 1553 Manchester encoder.
- Accepts command/status or data words through a small FIFO and serialises them with 1553 sync, Manchester bits and parity.
- Supports configurable word width, half-bit stretch, parity sense and inter-word gap.
- Sits between the RT/BC protocol controller and the bus transmitter, and sends contiguous multi-word messages without upstream cycle-exact timing.

---
 rtl/encoder_1553_queued.sv | 114 +++++++++++
 tb/tb_encoder_1553_queued.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_1553_queued.sv
// encoder_1553_queued: FIFO-fed 1553 Manchester word serialiser with sync, parity and optional inter-word gap
module encoder_1553_queued #(
   parameter int DATA_W        = 16,
   parameter int CLKS_PER_HALF = 1,
   parameter int FIFO_DEPTH    = 4,
   parameter int ODD_PARITY    = 1,
   parameter int GAP_HALFBITS  = 0
) (
   input  logic                                  enc_clk,
   input  logic                                  rst,
   input  logic [DATA_W-1:0]                     tx_dword,
   input  logic                                  tx_csw,
   input  logic                                  tx_dw,
   output logic                                  tx_full,
   output logic                                  tx_ovf,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]       tx_level,
   output logic                                  tx_busy,
   output logic                                  tx_data,
   output logic                                  tx_dval,
   output logic                                  tx_word_done
);
   localparam int H  = 2 * (DATA_W + 4);
   localparam int G  = GAP_HALFBITS * CLKS_PER_HALF;
   localparam int HW = $clog2(H);
   localparam int SW = CLKS_PER_HALF > 1 ? $clog2(CLKS_PER_HALF) : 1;
   localparam int GW = G > 1 ? $clog2(G) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t            state, state_n;
   logic [DATA_W:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [LW-1:0]     level_n;
   logic [H-1:0]      sh, frame_new;
   logic [HW-1:0]     hb_cnt;
   logic [SW-1:0]     sub_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [DATA_W:0]   head;
   logic              wr_req, push, pop, not_empty, par;
   logic              half_end, word_end, gap_end;

   assign wr_req    = tx_csw | tx_dw;
   assign not_empty = tx_level != '0;
   assign push      = wr_req & (!tx_full | pop);
   assign level_n   = (push && !pop) ? tx_level + LW'(1) :
                      (!push && pop) ? tx_level - LW'(1) : tx_level;
   assign tx_busy   = (state != IDLE) | not_empty;
   assign head      = mem[rd_ptr];
   assign par       = (^head[DATA_W-1:0]) ^ (ODD_PARITY != 0);
   assign half_end  = sub_cnt == SW'(CLKS_PER_HALF - 1);
   assign word_end  = half_end && hb_cnt == HW'(H - 1);
   assign gap_end   = gap_cnt == GW'(G > 0 ? G - 1 : 0);

   // Frame is built MSB-first so the shifter just emits its top bit
   always_comb begin
      frame_new = '0;
      frame_new[H-1 -: 6] = head[DATA_W] ? 6'b111000 : 6'b000111;
      for (int i = 0; i < DATA_W; i++)
         frame_new[2*i+3 -: 2] = {head[i], ~head[i]};
      frame_new[1:0] = {par, ~par};
   end

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      if (state == IDLE) begin
         pop     = not_empty;
         state_n = not_empty ? SHIFT : IDLE;
      end else if (state == SHIFT && word_end) begin
         pop     = G == 0 && not_empty;
         state_n = G != 0 ? GAP : not_empty ? SHIFT : IDLE;
      end else if (state == GAP && gap_end) begin
         pop     = not_empty;
         state_n = not_empty ? SHIFT : IDLE;
      end
   end

   always_ff @(posedge enc_clk)
      if (push) mem[wr_ptr] <= {tx_csw, tx_dword};

   always_ff @(posedge enc_clk) begin
      if (rst) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         tx_level     <= '0;
         tx_full      <= 1'b0;
         tx_ovf       <= 1'b0;
         sh           <= '0;
         hb_cnt       <= '0;
         sub_cnt      <= '0;
         gap_cnt      <= '0;
         tx_data      <= 1'b0;
         tx_dval      <= 1'b0;
         tx_word_done <= 1'b0;
      end else begin
         state        <= state_n;
         wr_ptr       <= push ? wr_ptr + PW'(1) : wr_ptr;
         rd_ptr       <= pop ? rd_ptr + PW'(1) : rd_ptr;
         tx_level     <= level_n;
         tx_full      <= level_n == LW'(FIFO_DEPTH);
         tx_ovf       <= wr_req & ~push;
         sh           <= pop ? frame_new : (state == SHIFT && half_end) ? sh << 1 : sh;
         hb_cnt       <= (pop || state != SHIFT) ? '0 : half_end ? hb_cnt + HW'(1) : hb_cnt;
         sub_cnt      <= (state != SHIFT || half_end) ? '0 : sub_cnt + SW'(1);
         gap_cnt      <= state == GAP ? gap_cnt + GW'(1) : '0;
         tx_data      <= state == SHIFT && sh[H-1];
         tx_dval      <= state == SHIFT;
         tx_word_done <= state == SHIFT && word_end;
      end
   end
endmodule

// File: tb/tb_encoder_1553_queued.sv
// tb_encoder_1553_queued: scoreboard bench for three encoder configurations sharing one stimulus stream
module tb_encoder_1553_queued;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] tx_dword = '0;
   logic        tx_csw = 1'b0;
   logic        tx_dw = 1'b0;
   logic [2:0]  full, ovf, busy, data, dval, wd;
   logic [2:0]  lvl [3];
   logic [1:0]  q0 [$];
   logic [1:0]  q1 [$];
   logic [1:0]  q2 [$];
   logic [1:0]  e;
   int          checks = 0;
   int          failures = 0;
   int          wd_cnt0 = 0;
   int          ovf_cnt0 = 0;

   always #5 clk = ~clk;

   encoder_1553_queued u0 (
      .enc_clk(clk), .rst(rst), .tx_dword(tx_dword), .tx_csw(tx_csw), .tx_dw(tx_dw),
      .tx_full(full[0]), .tx_ovf(ovf[0]), .tx_level(lvl[0]), .tx_busy(busy[0]),
      .tx_data(data[0]), .tx_dval(dval[0]), .tx_word_done(wd[0]));
   encoder_1553_queued #(.ODD_PARITY(0)) u1 (
      .enc_clk(clk), .rst(rst), .tx_dword(tx_dword), .tx_csw(tx_csw), .tx_dw(tx_dw),
      .tx_full(full[1]), .tx_ovf(ovf[1]), .tx_level(lvl[1]), .tx_busy(busy[1]),
      .tx_data(data[1]), .tx_dval(dval[1]), .tx_word_done(wd[1]));
   encoder_1553_queued #(.CLKS_PER_HALF(2), .GAP_HALFBITS(4)) u2 (
      .enc_clk(clk), .rst(rst), .tx_dword(tx_dword), .tx_csw(tx_csw), .tx_dw(tx_dw),
      .tx_full(full[2]), .tx_ovf(ovf[2]), .tx_level(lvl[2]), .tx_busy(busy[2]),
      .tx_data(data[2]), .tx_dval(dval[2]), .tx_word_done(wd[2]));

   function automatic logic [39:0] frame(logic csw, logic [15:0] d, logic odd);
      logic [39:0] f;
      logic p;
      f[39:34] = csw ? 6'b111000 : 6'b000111;
      for (int i = 0; i < 16; i++) f[2*i+3 -: 2] = {d[i], ~d[i]};
      p = (^d) ^ odd;
      f[1:0] = {p, ~p};
      return f;
   endfunction

   function automatic int qsize(int k);
      return k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
   endfunction

   task automatic push_q(int k, logic [1:0] v);
      if (k == 0) q0.push_back(v);
      else if (k == 1) q1.push_back(v);
      else q2.push_back(v);
   endtask

   task automatic pop_q(int k, output logic [1:0] v);
      if (k == 0) v = q0.pop_front();
      else if (k == 1) v = q1.pop_front();
      else v = q2.pop_front();
   endtask

   task automatic push_frame(int k, logic [39:0] f, int cph);
      for (int h = 39; h >= 0; h--)
         for (int c = 0; c < cph; c++) push_q(k, {h == 0 && c == cph - 1, f[h]});
   endtask

   // u0 gets the hand-written frame; u1 (even parity) and u2 (stretched) use the model
   task automatic expect_word(logic csw, logic [15:0] d, logic [39:0] lit0);
      push_frame(0, lit0, 1);
      push_frame(1, frame(csw, d, 1'b0), 1);
      push_frame(2, frame(csw, d, 1'b1), 2);
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic wr(logic csw, logic dw, logic [15:0] d);
      tx_csw = csw;
      tx_dw = dw;
      tx_dword = d;
      @(posedge clk); #1;
      tx_csw = 1'b0;
      tx_dw = 1'b0;
   endtask

   task automatic run(int k, logic v, output int n);
      n = 0;
      while (dval[k] === v && n < 1000) begin
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_dval(int k);
      int t = 0;
      while (dval[k] !== 1'b1 && t < 100) begin
         t++;
         @(posedge clk); #1;
      end
      chk($sformatf("wait_dval_u%0d_timeout", k), int'(t >= 100), 0);
   endtask

   task automatic drain();
      int t = 0;
      while ((qsize(0) + qsize(1) + qsize(2) != 0 || busy != 3'b000) && t < 3000) begin
         t++;
         @(posedge clk); #1;
      end
      chk("drain_timeout", int'(t >= 3000), 0);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   always @(negedge clk) begin
      if (wd[0]) wd_cnt0++;
      if (ovf[0]) ovf_cnt0++;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dval[k]) begin
            if (qsize(k) == 0) begin
               failures++;
               $display("FAIL stream_extra u%0d data=%0d done=%0d", k, data[k], wd[k]);
            end else begin
               pop_q(k, e);
               if ({wd[k], data[k]} !== e) begin
                  failures++;
                  $display("FAIL stream u%0d {done,data} actual=%b expected=%b left=%0d", k, {wd[k], data[k]}, e, qsize(k));
               end
            end
         end else if (data[k] !== 1'b0 || wd[k] !== 1'b0) begin
            failures++;
            $display("FAIL idle_out u%0d data=%0d done=%0d expected 0", k, data[k], wd[k]);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, base;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_dval_u%0d", k), dval[k], 0);
         chk($sformatf("rst_level_u%0d", k), lvl[k], 0);
         chk($sformatf("rst_full_u%0d", k), full[k], 0);
         chk($sformatf("rst_busy_u%0d", k), busy[k], 0);
      end
      chk("rst_ovf", ovf[0], 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // single data word, latency and length
      expect_word(1'b0, 16'hA5A5, {6'b000111, 16'b1001100101100110, 16'b1001100101100110, 2'b10});
      wr(1'b0, 1'b1, 16'hA5A5);
      chk("single_level_after_write", lvl[0], 1);
      chk("single_dval_edge1", dval[0], 0);
      @(posedge clk); #1;
      chk("single_dval_edge2", dval[0], 0);
      chk("single_level_after_pop", lvl[0], 0);
      @(posedge clk); #1;
      chk("single_dval_first", dval[0], 1);
      run(0, 1'b1, n);
      chk("single_dval_len", n, 40);
      drain();
      for (int k = 0; k < 3; k++) chk($sformatf("single_busy_idle_u%0d", k), busy[k], 0);

      // command/status zero word, odd vs even parity
      push_frame(0, {6'b111000, {16{2'b01}}, 2'b10}, 1);
      push_frame(1, {6'b111000, {16{2'b01}}, 2'b01}, 1);
      push_frame(2, frame(1'b1, 16'h0000, 1'b1), 2);
      wr(1'b1, 1'b0, 16'h0000);
      drain();

      // contiguous three-word message; second word has both strobes
      base = wd_cnt0;
      expect_word(1'b0, 16'h1234, frame(1'b0, 16'h1234, 1'b1));
      expect_word(1'b1, 16'h8001, frame(1'b1, 16'h8001, 1'b1));
      expect_word(1'b0, 16'hFFFF, {6'b000111, {16{2'b10}}, 2'b10});
      wr(1'b0, 1'b1, 16'h1234);
      wr(1'b1, 1'b1, 16'h8001);
      wr(1'b0, 1'b1, 16'hFFFF);
      wait_dval(0);
      run(0, 1'b1, n);
      chk("contig_dval_len", n, 120);
      chk("contig_word_done_count", wd_cnt0 - base, 3);
      drain();
      chk("contig_level_end", lvl[0], 0);

      // overflow: six back-to-back writes into depth 4
      base = ovf_cnt0;
      for (int i = 1; i <= 5; i++)
         expect_word(1'b0, 16'(i * 16'h1111), frame(1'b0, 16'(i * 16'h1111), 1'b1));
      wr(1'b0, 1'b1, 16'h1111);
      wr(1'b0, 1'b1, 16'h2222);
      chk("ovf_level_w2", lvl[0], 1);
      wr(1'b0, 1'b1, 16'h3333);
      chk("ovf_level_w3", lvl[0], 2);
      wr(1'b0, 1'b1, 16'h4444);
      chk("ovf_level_w4", lvl[0], 3);
      chk("ovf_full_w4", full[0], 0);
      wr(1'b0, 1'b1, 16'h5555);
      chk("ovf_level_w5", lvl[0], 4);
      chk("ovf_full_w5", full[0], 1);
      chk("ovf_pulse_before", ovf[0], 0);
      wr(1'b0, 1'b1, 16'h6666);
      chk("ovf_pulse", ovf[0], 1);
      chk("ovf_level_w6", lvl[0], 4);
      @(posedge clk); #1;
      chk("ovf_pulse_end", ovf[0], 0);
      drain();
      chk("ovf_pulse_count", ovf_cnt0 - base, 1);
      chk("ovf_full_end", full[0], 0);

      // gap and stretch on u2
      expect_word(1'b1, 16'hABCD, frame(1'b1, 16'hABCD, 1'b1));
      expect_word(1'b0, 16'h0F0F, frame(1'b0, 16'h0F0F, 1'b1));
      wr(1'b1, 1'b0, 16'hABCD);
      wr(1'b0, 1'b1, 16'h0F0F);
      wait_dval(2);
      run(2, 1'b1, n);
      chk("gap_first_high", n, 80);
      run(2, 1'b0, n);
      chk("gap_low", n, 8);
      run(2, 1'b1, n);
      chk("gap_second_high", n, 80);
      drain();

      // reset during half-bit 10 of u0
      expect_word(1'b0, 16'h5A5A, frame(1'b0, 16'h5A5A, 1'b1));
      wr(1'b0, 1'b1, 16'h5A5A);
      wait_dval(0);
      repeat (10) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      q0.delete();
      q1.delete();
      q2.delete();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("midrst_dval_u%0d", k), dval[k], 0);
         chk($sformatf("midrst_level_u%0d", k), lvl[k], 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_busy_after", busy[0], 0);
      expect_word(1'b0, 16'hFFFF, {6'b000111, {16{2'b10}}, 2'b10});
      wr(1'b0, 1'b1, 16'hFFFF);
      wait_dval(0);
      run(0, 1'b1, n);
      chk("midrst_clean_len", n, 40);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
